// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - iterative round-constant permutation engine with valid/ready handshakes
module ascon_perm_engine #(
  parameter int WIDTH  = 128,
  parameter int SHIFT  = 8,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] state_in,
  input  logic [3:0]       rounds_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] state_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_IDX = 4'd12;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       idx_q;
  logic [WIDTH-1:0] chain;
  logic [3:0]       idx_next;
  logic [3:0]       n_norm;
  logic [3:0]       start_idx;
  logic             accept;

  // 12-entry round constant table; jobs of N rounds use its last N entries.
  function automatic logic [7:0] round_const(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'hf0;
      4'd1:    c = 8'he1;
      4'd2:    c = 8'hd2;
      4'd3:    c = 8'hc3;
      4'd4:    c = 8'hb4;
      4'd5:    c = 8'ha5;
      4'd6:    c = 8'h96;
      4'd7:    c = 8'h87;
      4'd8:    c = 8'h78;
      4'd9:    c = 8'h69;
      4'd10:   c = 8'h5a;
      4'd11:   c = 8'h4b;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // One round: inject the constant into the low byte, then fold in a logical right shift.
  function automatic logic [WIDTH-1:0] round_fn(input logic [WIDTH-1:0] s, input logic [3:0] i);
    logic [WIDTH-1:0] t;
    t = s ^ WIDTH'(round_const(i));
    return t ^ (t >> SHIFT);
  endfunction

  // Zero or out-of-range round counts run the full 12-round schedule.
  always_comb begin
    n_norm = rounds_in;
    if (rounds_in == 4'd0 || rounds_in > LAST_IDX) begin
      n_norm = LAST_IDX;
    end
    start_idx = LAST_IDX - n_norm;
  end

  // Chain up to UNROLL rounds this clock, stopping early once index 12 is reached.
  always_comb begin
    chain    = work_q;
    idx_next = idx_q;
    for (int u = 0; u < UNROLL; u++) begin
      if (idx_next < LAST_IDX) begin
        chain    = round_fn(chain, idx_next);
        idx_next = idx_next + 4'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state and handshake outputs; a result handshake returns to IDLE without a same-cycle accept.
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          fsm_d  = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx_next == LAST_IDX) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // Working state and round index; the result register only changes on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      idx_q  <= 4'd0;
      res_q  <= '0;
    end else if (accept) begin
      work_q <= state_in;
      idx_q  <= start_idx;
    end else if (fsm_q == RUN) begin
      work_q <= chain;
      idx_q  <= idx_next;
      if (idx_next == LAST_IDX) begin
        res_q <= chain;
      end
    end
  end

  assign state_out = res_q;

endmodule
